// File: rtl/subtract_pkg.sv
// ============================================================================
//  Module   : subtract_pkg
//  Brief    : Shared types and helpers for the background-subtract sequencer.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package subtract_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } subtract_state_t;

    // Wide enough to hold the pixel count of a full frame, inclusive.
    function automatic int cnt_width(input int w, input int h);
        return $clog2(w * h + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/subtract_ctrl_if.sv
// ============================================================================
//  Module   : subtract_ctrl_if
//  Brief    : FIFO and core-pipeline handshake bundle for subtract_ctrl.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface subtract_ctrl_if;

    logic base_empty;
    logic base_rd_en;
    logic img_empty;
    logic img_rd_en;
    logic pipe_en;
    logic out_full;
    logic out_wr_en;

    modport master (
        input  base_empty,
        output base_rd_en,
        input  img_empty,
        output img_rd_en,
        output pipe_en,
        input  out_full,
        output out_wr_en
    );

    modport slave (
        output base_empty,
        input  base_rd_en,
        output img_empty,
        input  img_rd_en,
        input  pipe_en,
        output out_full,
        input  out_wr_en
    );

endinterface

`default_nettype wire

// File: rtl/subtract_valid_pipe.sv
// ============================================================================
//  Module   : subtract_valid_pipe
//  Brief    : DEPTH-stage valid shift register with advance enable.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module subtract_valid_pipe #(
    parameter int DEPTH = 2
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic i_en,
    input  wire logic i_vld,
    output logic      o_vld
);

    logic [DEPTH-1:0] r_vld;

    generate
        if (DEPTH > 1) begin : g_shift
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_vld <= '0;
                end else if (i_en) begin
                    r_vld <= {r_vld[DEPTH-2:0], i_vld};
                end
            end
        end else begin : g_single
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_vld <= '0;
                end else if (i_en) begin
                    r_vld <= i_vld;
                end
            end
        end
    endgenerate

    assign o_vld = r_vld[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/subtract_ctrl.sv
// ============================================================================
//  Module   : subtract_ctrl
//  Brief    : Frame sequencer popping paired base/image pixels through a
//             stall-able core pipeline into the output FIFO.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module subtract_ctrl
    import subtract_pkg::*;
#(
    parameter int WIDTH        = 720,
    parameter int HEIGHT       = 540,
    parameter int PIPE_LATENCY = 2
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             start,
    input  wire logic [PIX_W-1:0] threshold_in,
    output logic      [PIX_W-1:0] threshold,
    output logic                  busy,
    output logic                  frame_done,
    subtract_ctrl_if.master       fifo
);

    localparam int                 c_CNT_W = cnt_width(WIDTH, HEIGHT);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH * HEIGHT - 1);

    subtract_state_t    r_state;
    logic [c_CNT_W-1:0] r_issued;
    logic [c_CNT_W-1:0] r_written;
    logic [PIX_W-1:0]   r_threshold;
    logic               r_busy;
    logic               r_frame_done;

    logic w_vld_last;
    logic w_pipe_en;
    logic w_issue;
    logic w_wr;

    // A full output FIFO only blocks the pipe when the last stage holds data;
    // otherwise bubbles keep collapsing.
    assign w_pipe_en = !(w_vld_last && fifo.out_full);
    assign w_issue   = (r_state == RUN) && !fifo.base_empty && !fifo.img_empty && w_pipe_en;
    assign w_wr      = w_vld_last && !fifo.out_full;

    assign fifo.base_rd_en = w_issue;
    assign fifo.img_rd_en  = w_issue;
    assign fifo.pipe_en    = w_pipe_en;
    assign fifo.out_wr_en  = w_wr;

    assign threshold  = r_threshold;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

    subtract_valid_pipe #(
        .DEPTH (PIPE_LATENCY)
    ) u_valid_pipe (
        .clock (clock),
        .reset (reset),
        .i_en  (w_pipe_en),
        .i_vld (w_issue),
        .o_vld (w_vld_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_issued     <= '0;
            r_written    <= '0;
            r_threshold  <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_issue) begin
                r_issued <= r_issued + c_CNT_W'(1);
            end
            if (w_wr) begin
                r_written <= r_written + c_CNT_W'(1);
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_threshold <= threshold_in;
                        r_issued    <= '0;
                        r_written   <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= RUN;
                    end
                end
                RUN: begin
                    if (w_issue && (r_issued == c_LAST)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_wr && (r_written == c_LAST)) begin
                        r_frame_done <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_subtract_ctrl.sv
// ============================================================================
//  Module   : tb_subtract_ctrl
//  Brief    : Scoreboard bench for subtract_ctrl with an 8-pixel (4x2) frame.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_subtract_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] threshold_in;
    logic [7:0] threshold;
    logic       busy;
    logic       frame_done;

    subtract_ctrl_if bus ();

    subtract_ctrl #(
        .WIDTH        (4),
        .HEIGHT       (2),
        .PIPE_LATENCY (2)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .threshold_in (threshold_in),
        .threshold    (threshold),
        .busy         (busy),
        .frame_done   (frame_done),
        .fifo         (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // FIFO occupancy models
    int base_cnt  = 0;
    int img_cnt   = 0;
    bit img_block = 1'b0;
    bit full_force = 1'b0;

    assign bus.base_empty = (base_cnt == 0);
    assign bus.img_empty  = (img_cnt == 0) || img_block;
    assign bus.out_full   = full_force;

    int cyc = 0;
    bit s_base = 1'b0;
    bit s_img  = 1'b0;
    int pop_id = 0;
    int exp_q[$];
    int core_d[0:1] = '{-1, -1};

    int n_pop, n_wr, first_pop, last_pop, first_wr, last_wr, done_cyc, busy_low_cyc;
    int split_pop, full_wr, full_viol;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_pop = 0; n_wr = 0; first_pop = -1; last_pop = -1; first_wr = -1; last_wr = -1;
        done_cyc = -1; busy_low_cyc = -1; split_pop = 0; full_wr = 0; full_viol = 0;
    endtask

    // Monitor: samples mid-cycle, checks writes against the popped order
    always @(negedge clock) begin
        s_base = bus.base_rd_en;
        s_img  = bus.img_rd_en;
        if (bus.base_rd_en != bus.img_rd_en) split_pop++;
        if (bus.out_full && bus.out_wr_en) full_wr++;
        if (full_force && (bus.pipe_en || bus.base_rd_en)) full_viol++;
        if (bus.out_wr_en) begin
            n_wr++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            if (exp_q.size() == 0) check("wr_unexpected", core_d[1], -99);
            else check("wr_order", core_d[1], exp_q.pop_front());
        end
        if (bus.base_rd_en) begin
            n_pop++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            exp_q.push_back(pop_id);
        end
        if (bus.pipe_en) begin
            core_d[1] = core_d[0];
            core_d[0] = bus.base_rd_en ? pop_id : -1;
        end
        if (bus.base_rd_en) pop_id++;
        if (frame_done && done_cyc < 0) done_cyc = cyc;
        if (done_cyc >= 0 && !busy && busy_low_cyc < 0) busy_low_cyc = cyc;
        cyc++;
    end

    // FIFO pops take effect at the clock edge that consumed them
    always @(posedge clock) begin
        #1;
        if (s_base) base_cnt--;
        if (s_img)  img_cnt--;
        s_base = 1'b0;
        s_img  = 1'b0;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] th, output int t0);
        start = 1'b1;
        threshold_in = th;
        t0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (done_cyc < 0 && k < 80) begin
            tick();
            k++;
        end
        if (done_cyc < 0) check({name, "_timeout"}, 0, 1);
        tick();
        tick();
    endtask

    initial begin
        int t0;
        reset = 1'b1;
        start = 1'b0;
        threshold_in = 8'h00;
        clear_stats();
        tick();
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_threshold", threshold, 0);
        check("rst_out_wr_en", bus.out_wr_en, 0);
        check("rst_base_rd_en", bus.base_rd_en, 0);
        check("rst_pipe_en", bus.pipe_en, 1);
        tick();

        // Nominal frame; threshold changes mid-frame must not leak through
        clear_stats();
        base_cnt = 8; img_cnt = 8;
        pulse_start(8'h40, t0);
        tick(); tick();
        threshold_in = 8'h90;
        wait_done("s1");
        check("s1_first_pop", first_pop, t0 + 1);
        check("s1_last_pop", last_pop, t0 + 8);
        check("s1_n_pop", n_pop, 8);
        check("s1_first_wr", first_wr, t0 + 3);
        check("s1_last_wr", last_wr, t0 + 10);
        check("s1_n_wr", n_wr, 8);
        check("s1_done", done_cyc, t0 + 11);
        check("s1_busy_low", busy_low_cyc, t0 + 12);
        check("s1_threshold", threshold, 8'h40);
        check("s1_queue_left", exp_q.size(), 0);

        // Image FIFO dry for three cycles
        clear_stats();
        base_cnt = 8; img_cnt = 8;
        pulse_start(8'h90, t0);
        tick(); tick(); tick();
        img_block = 1'b1;
        tick(); tick(); tick();
        img_block = 1'b0;
        wait_done("s2");
        check("s2_split_pop", split_pop, 0);
        check("s2_n_pop", n_pop, 8);
        check("s2_last_pop", last_pop, t0 + 11);
        check("s2_done", done_cyc, t0 + 14);
        check("s2_threshold", threshold, 8'h90);

        // Output full for four cycles with data at the last stage
        clear_stats();
        base_cnt = 8; img_cnt = 8;
        pulse_start(8'h21, t0);
        tick(); tick(); tick(); tick();
        full_force = 1'b1;
        tick(); tick(); tick(); tick();
        full_force = 1'b0;
        wait_done("s3");
        check("s3_stall_viol", full_viol, 0);
        check("s3_write_while_full", full_wr, 0);
        check("s3_n_wr", n_wr, 8);
        check("s3_n_pop", n_pop, 8);
        check("s3_last_wr", last_wr, t0 + 14);
        check("s3_done", done_cyc, t0 + 15);

        // Second start during RUN is ignored; surplus words stay queued
        clear_stats();
        base_cnt = 12; img_cnt = 12;
        pulse_start(8'h55, t0);
        tick(); tick();
        start = 1'b1;
        threshold_in = 8'hAA;
        tick();
        start = 1'b0;
        wait_done("s5");
        check("s5_n_pop", n_pop, 8);
        check("s5_base_left", base_cnt, 4);
        check("s5_img_left", img_cnt, 4);
        check("s5_done", done_cyc, t0 + 11);
        check("s5_threshold", threshold, 8'h55);
        base_cnt = 0; img_cnt = 0;
        tick();

        // Reset after five writes, then a fresh frame
        clear_stats();
        base_cnt = 8; img_cnt = 8;
        pulse_start(8'h33, t0);
        for (int k = 0; k < 40 && n_wr < 5; k++) tick();
        check("s6_reach_5_writes", n_wr, 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("s6_busy", busy, 0);
        check("s6_out_wr_en", bus.out_wr_en, 0);
        check("s6_frame_done", frame_done, 0);
        check("s6_base_rd_en", bus.base_rd_en, 0);
        check("s6_threshold", threshold, 0);
        tick();
        exp_q.delete();
        core_d = '{-1, -1};
        clear_stats();
        base_cnt = 8; img_cnt = 8;
        pulse_start(8'h34, t0);
        wait_done("s6b");
        check("s6b_n_pop", n_pop, 8);
        check("s6b_n_wr", n_wr, 8);
        check("s6b_done", done_cyc, t0 + 11);
        check("s6b_queue_left", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/subtract_ctrl.md
# subtract_ctrl

Frame sequencer for the grayscale background-subtract datapath. Pops paired pixels from the base and image input FIFOs in lockstep, and drives a stall-able valid pipeline alongside the subtract/threshold core. Writes results into the output FIFO without overflow, counts one WIDTH×HEIGHT frame per `start`, and latches the threshold configuration for that frame.

## Interface
- `WIDTH`, 720, frame width in pixels
- `HEIGHT`, 540, frame height in pixels
- `PIPE_LATENCY`, 2, core pipeline depth in cycles, ≥1
- `clock`  in  1  system clock; single clock domain
- `reset`  in  1  synchronous, active-high; clears all state
- `start`  in  1  one-cycle pulse; begins a frame when idle
- `threshold_in`  in  8  mask threshold, sampled on accepted `start`
- `threshold`  out  8  latched threshold to core, reset 0
- `busy`  out  1  high from accepted start until `frame_done`, reset 0
- `frame_done`  out  1  one-cycle pulse after last pixel written, reset 0
- `base_empty`  in  1  base FIFO empty (first-word-fall-through)
- `base_rd_en`  out  1  pop base FIFO, reset 0
- `img_empty`  in  1  image FIFO empty (first-word-fall-through)
- `img_rd_en`  out  1  pop image FIFO, reset 0
- `pipe_en`  out  1  global advance enable for core pipeline, reset 1
- `out_full`  in  1  output FIFO full
- `out_wr_en`  out  1  push output FIFO, reset 0

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE (enum in package).
- IDLE: `busy`=0. `start`=1 causes the following:
  - latch `threshold_in` into `threshold`
  - clear the issue and write counters
  - go to RUN
- `start` in any state other than IDLE is ignored.
- Issue condition: `issue` = RUN ∧ ¬`base_empty` ∧ ¬`img_empty` ∧ `pipe_en`.
  - `base_rd_en` = `img_rd_en` = `issue`.
  - The two FIFOs are never popped independently.
- Valid pipeline: `vld[0..PIPE_LATENCY-1]`.
  - Loads `issue` into `vld[0]` when `pipe_en`.
  - Holds all stages when ¬`pipe_en`.
- Stall: `pipe_en` = ¬(`vld[last]` ∧ `out_full`).
- Output: `out_wr_en` = `vld[last]` ∧ ¬`out_full`.
- Counters: `issued` and `written` are `$clog2(WIDTH*HEIGHT+1)` bits wide. Total N = WIDTH×HEIGHT.
- RUN→DRAIN in the cycle `issue` fires with `issued` = N−1. No issue occurs after that.
- DRAIN→DONE in the cycle `out_wr_en` fires with `written` = N−1.
- DONE: `frame_done`=1 for one cycle, `busy` still 1. Next cycle → IDLE.
- Surplus FIFO data beyond N pixels stays unread for the next frame.

## Timing
- Pop-to-write latency is PIPE_LATENCY cycles when unstalled.
  - A pair popped in cycle t is written in cycle t+PIPE_LATENCY.
  - Each stall cycle adds one cycle.
- Sustained throughput is 1 pixel/cycle when both inputs are non-empty and the output is not full.
- Empty on either input: no pop that cycle. Bubbles propagate; already-issued pixels still drain.
- `out_full` with `vld[last]`=1: the whole pipeline freezes, including issue. No data is lost or duplicated.
- `out_full` with `vld[last]`=0: the pipeline advances and collapses bubbles.
- `out_full` deasserting: write occurs in the same cycle.
- `start` and the final write in the same cycle: `start` is ignored, because the FSM is not in IDLE.
- `reset` mid-frame has the following effect:
  - next cycle in IDLE
  - all outputs at their reset values
  - counters and `vld` cleared
  - in-flight pixels discarded
- The FIFOs themselves are not cleared by this block.
- First pop can occur in the cycle after `start` at the earliest.

## Structure
- `subtract_pkg` holds:
  - the state enum `subtract_state_t`
  - `PIX_W` = 8
  - the counter-width function
- One sub-module, `subtract_valid_pipe`: PIPE_LATENCY-deep valid shift register with enable and synchronous reset.
- The FSM and the counters live in `subtract_ctrl`.

## Test plan
All scenarios use WIDTH=4, HEIGHT=2 (N=8) and PIPE_LATENCY=2.
- Both FIFOs hold 8 pixels, output never full, `start` at t0:
  - pops in t0+1..t0+8
  - `out_wr_en` in t0+3..t0+10
  - `frame_done` at t0+11, `busy` low at t0+12
- Img FIFO empty for 3 cycles mid-frame:
  - `base_rd_en` never asserts without `img_rd_en`
  - exactly 8 pops of each FIFO
  - `frame_done` delayed by 3 cycles
- `out_full` held 4 cycles while `vld[last]`=1:
  - `pipe_en`=0 and no pops during those cycles
  - 8 writes total, in order
  - `frame_done` delayed by 4 cycles
- `threshold_in`=0x40 at `start`, then changed to 0x90 mid-frame: `threshold` stays 0x40 until the next accepted start.
- `start` pulsed again during RUN, and a FIFO holds 12 pixels: second start ignored; exactly 8 pops; 4 words remain.
- `reset` asserted after 5 writes:
  - next cycle IDLE; `busy`, `out_wr_en`, `frame_done` all 0
  - a fresh `start` produces a full 8-pixel frame
